// File: rtl/debounce_pkg.sv
// Shared state encoding for the key debouncer.
package debounce_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    S_LO    = 2'd0,
    S_LO2HI = 2'd1,
    S_HI    = 2'd2,
    S_HI2LO = 2'd3
  } state_e;

endpackage

// File: rtl/sync_ff.sv
// SYNC_STAGES-deep flop chain that brings an asynchronous level into the clk domain.
module sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/key_debounce.sv
// Synchronise and debounce a raw button level into a clean registered key_out.
// Define DEBOUNCE_EDGE_EN to add the one-cycle key_rise/key_fall pulses.
module key_debounce
  import debounce_pkg::*;
#(
  parameter int CNT_MAX     = 1_000_000,
  parameter int CNT_W       = 20,
  parameter int SYNC_STAGES = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               key_in,
  output logic [STATE_W-1:0] state_o,
  output logic               key_out
`ifdef DEBOUNCE_EDGE_EN
  ,
  output logic               key_rise,
  output logic               key_fall
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);

  logic             key_sync;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             key_out_q, key_out_d;
`ifdef DEBOUNCE_EDGE_EN
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
`endif

  sync_ff #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk (clk),
    .rstn(rstn),
    .d_i (key_in),
    .q_o (key_sync)
  );

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= S_LO;
      cnt_q     <= '0;
      key_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      key_out_q <= key_out_d;
    end
  end

`ifdef DEBOUNCE_EDGE_EN
  always_ff @(posedge clk) begin
    if (!rstn) begin
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
`endif

  // The counter only runs while key_sync disagrees with key_out; any return restarts it.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    key_out_d = key_out_q;
`ifdef DEBOUNCE_EDGE_EN
    rise_d    = 1'b0;
    fall_d    = 1'b0;
`endif
    case (state_q)
      S_LO: begin
        if (key_sync) begin
          state_d = S_LO2HI;
          cnt_d   = '0;
        end
      end
      S_LO2HI: begin
        if (!key_sync) begin
          state_d = S_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_HI;
          cnt_d     = '0;
          key_out_d = 1'b1;
`ifdef DEBOUNCE_EDGE_EN
          rise_d    = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_HI: begin
        if (!key_sync) begin
          state_d = S_HI2LO;
          cnt_d   = '0;
        end
      end
      S_HI2LO: begin
        if (key_sync) begin
          state_d = S_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = S_LO;
          cnt_d     = '0;
          key_out_d = 1'b0;
`ifdef DEBOUNCE_EDGE_EN
          fall_d    = 1'b1;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d   = S_LO;
        cnt_d     = '0;
        key_out_d = 1'b0;
      end
    endcase
  end

  assign state_o = state_q;
  assign key_out = key_out_q;
`ifdef DEBOUNCE_EDGE_EN
  assign key_rise = rise_q;
  assign key_fall = fall_q;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: run-length reference model checked every cycle plus directed scenarios.
module tb_key_debounce;

  localparam int CNT_MAX     = 4;
  localparam int CNT_W       = 3;
  localparam int SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       key_in = 1'b0;
  logic [1:0] state_o;
  logic       key_out;
`ifdef DEBOUNCE_EDGE_EN
  logic       key_rise;
  logic       key_fall;
`endif

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  // clock / reset
  always #5 clk = ~clk;

  key_debounce #(
    .CNT_MAX    (CNT_MAX),
    .CNT_W      (CNT_W),
    .SYNC_STAGES(SYNC_STAGES)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .key_in  (key_in),
    .state_o (state_o),
    .key_out (key_out)
`ifdef DEBOUNCE_EDGE_EN
    ,
    .key_rise(key_rise),
    .key_fall(key_fall)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the level seen by the debouncer lags key_in by SYNC_STAGES
  // samples; the output flips once it has disagreed for CNT_MAX+1 samples in a row.
  logic [SYNC_STAGES-1:0] m_hist;
  logic m_seen, m_out, m_rise, m_fall;
  int   m_run;

  always @(posedge clk) begin
    if (!rstn) begin
      m_hist = '0;
      m_run  = 0;
      m_out  = 1'b0;
      m_rise = 1'b0;
      m_fall = 1'b0;
    end else begin
      m_seen = m_hist[SYNC_STAGES-1];
      m_hist = {m_hist[SYNC_STAGES-2:0], key_in};
      m_rise = 1'b0;
      m_fall = 1'b0;
      if (m_seen != m_out) m_run++;
      else m_run = 0;
      if (m_run == CNT_MAX + 1) begin
        m_out  = ~m_out;
        m_rise = m_out;
        m_fall = ~m_out;
        m_run  = 0;
      end
    end
  end

  // scoreboard compare, every cycle away from the active edge
  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_key_out", 32'(key_out), 32'(m_out));
`ifdef DEBOUNCE_EDGE_EN
      check("model_key_rise", 32'(key_rise), 32'(m_rise));
      check("model_key_fall", 32'(key_fall), 32'(m_fall));
      if (key_rise && key_fall) check("rise_and_fall", 32'(1), 32'(0));
`endif
    end
  end

  // driver tasks: inputs change only on the falling edge
  task automatic hold_check(input string name, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(name, 32'(key_out), 32'(v));
`ifdef DEBOUNCE_EDGE_EN
      check({name, "_rise"}, 32'(key_rise), 32'(0));
      check({name, "_fall"}, 32'(key_fall), 32'(0));
`endif
    end
  endtask

  // Called right after an input change driven just past edge E0: key_out must
  // keep its old value through E0+6 and take the new one at E0+7.
  task automatic expect_change(input string name, input logic v);
    hold_check({name, "_early"}, ~v, 6);
    @(negedge clk);
    check({name, "_at7"}, 32'(key_out), 32'(v));
`ifdef DEBOUNCE_EDGE_EN
    check({name, "_rise_pulse"}, 32'(key_rise), 32'(v));
    check({name, "_fall_pulse"}, 32'(key_fall), 32'(~v));
`endif
    hold_check({name, "_after"}, v, 2);
  endtask

  logic [6:0] bounce_pat;

  initial begin
    rstn   = 1'b0;
    key_in = 1'b1;
    @(posedge clk);
    cmp_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("reset_key_out", 32'(key_out), 32'(0));
      check("reset_state", 32'(state_o), 32'(0));
`ifdef DEBOUNCE_EDGE_EN
      check("reset_rise", 32'(key_rise), 32'(0));
`endif
    end
    rstn = 1'b1;
    expect_change("reset_release_press", 1'b1);

    key_in = 1'b0;
    expect_change("release", 1'b0);

    key_in = 1'b1;
    expect_change("clean_press", 1'b1);

    key_in = 1'b0;
    hold_check("glitch_low", 1'b1, 3);
    key_in = 1'b1;
    hold_check("glitch_after", 1'b1, 10);

    key_in = 1'b0;
    expect_change("release2", 1'b0);

    // high 3, low 1, high 2, low 1
    bounce_pat = 7'b1110110;
    for (int i = 6; i >= 0; i--) begin
      key_in = bounce_pat[i];
      hold_check("bounce", 1'b0, 1);
    end
    key_in = 1'b1;
    expect_change("bounce_settle", 1'b1);

    key_in = 1'b0;
    expect_change("release3", 1'b0);

    for (int i = 0; i < 40; i++) begin
      key_in = ~key_in;
      hold_check("toggle", 1'b0, 1);
    end
    key_in = 1'b0;
    hold_check("toggle_quiet", 1'b0, 4);

    // key_in rises past E0; after E0+5 the debouncer is in S_LO2HI with cnt=2
    key_in = 1'b1;
    hold_check("mid_pre", 1'b0, 5);
    check("mid_state_lo2hi", 32'(state_o), 32'(1));
    rstn = 1'b0;
    @(negedge clk);
    check("mid_reset_key_out", 32'(key_out), 32'(0));
    check("mid_reset_state", 32'(state_o), 32'(0));
    rstn = 1'b1;
    expect_change("mid_reset_press", 1'b1);

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
